// File: rtl/stopwatch_core_v2_pkg.sv
// rtl/stopwatch_core_v2_pkg.sv - shared state codes and time-field layout for the stopwatch core
package stopwatch_core_v2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STOP      = 3'd2,
    ST_LAP_STORE = 3'd3,
    ST_CLEAR     = 3'd4
  } state_t;

  // Packed time word: {hour, min, sec, sub}, one byte per field
  localparam int HOUR_LSB = 24;
  localparam int MIN_LSB  = 16;
  localparam int SEC_LSB  = 8;
  localparam int SUB_LSB  = 0;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] sub;
  } time_t;

  function automatic logic [7:0] field_of(input logic [31:0] w, input int lsb);
    return w[lsb +: 8];
  endfunction

endpackage

// File: rtl/stopwatch_core_v2_bcd_free_field_cnt.sv
// rtl/stopwatch_core_v2_bcd_free_field_cnt.sv - one modulo-MAX up/down time field with carry/borrow chaining
module bcd_free_field_cnt #(
  parameter int MAX = 100
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_en,
  input  logic       i_hold,
  input  logic       i_down,
  output logic [7:0] o_val,
  output logic       o_carry
);

  localparam logic [7:0] TOP   = 8'(MAX - 1);
  localparam logic [7:0] LIMIT = 8'(MAX);

  logic [7:0] r_val;

  // Carry/borrow out depends only on the enable and the held value, so a
  // hold request from the top cannot loop back into the chain.
  assign o_carry = i_en && (i_down ? (r_val == 8'd0) : (r_val == TOP));
  assign o_val   = r_val;

  // Field register: clear, clamped preset, or one modulo step when enabled
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_val <= 8'd0;
    end else if (i_clr) begin
      r_val <= 8'd0;
    end else if (i_load) begin
      r_val <= (i_load_val >= LIMIT) ? 8'd0 : i_load_val;
    end else if (i_en && !i_hold) begin
      if (i_down) r_val <= (r_val == 8'd0) ? TOP : r_val - 8'd1;
      else        r_val <= (r_val == TOP) ? 8'd0 : r_val + 8'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core_v2.sv
// rtl/stopwatch_core_v2.sv - up/down stopwatch with lap buffer, preset load and countdown expiry
module stopwatch_core_v2
  import stopwatch_core_v2_pkg::*;
#(
  parameter int LAP_DEPTH   = 10,
  parameter int LAP_IDX_W   = 4,
  parameter int LAP_WRAP    = 1,
  parameter int MAX_SUB_SEC = 100,
  parameter int MAX_SEC     = 60,
  parameter int MAX_MIN     = 60,
  parameter int MAX_HOUR    = 100
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  input  logic                 iTICK,
  input  logic                 iSTART,
  input  logic                 iSTOP,
  input  logic                 iCLEAR,
  input  logic                 iSTORE,
  input  logic                 iLOAD,
  input  logic [31:0]          iLOAD_TIME,
  input  logic                 iMODE_DOWN,
  input  logic [LAP_IDX_W-1:0] iLAP_IDX,
  output logic [31:0]          oLAP_DATA,
  output logic [LAP_IDX_W-1:0] oLAP_CNT,
  output logic                 oLAP_FULL,
  output logic [31:0]          oCURR_TIME,
  output logic                 oEXPIRED,
  output logic                 oCLKGEN_RUN,
  output logic                 oCLKGEN_RST,
  output logic [2:0]           oSTATE
);

  localparam logic [LAP_IDX_W-1:0] LAP_FULL_CNT = LAP_IDX_W'(LAP_DEPTH);
  localparam logic [LAP_IDX_W-1:0] LAP_LAST     = LAP_IDX_W'(LAP_DEPTH - 1);
  localparam logic [LAP_IDX_W-1:0] LAP_ONE      = LAP_IDX_W'(1);

  state_t               r_state, w_next;
  logic                 r_ret_run, r_mode_down, r_expired, r_clkgen_run, r_clkgen_rst;
  logic [LAP_IDX_W-1:0] r_wr_ptr, r_lap_cnt;
  logic [31:0]          r_lap_mem [LAP_DEPTH];
  logic [31:0]          r_lap_data;
  time_t                w_time;
  logic [7:0]           w_hour, w_min, w_sec, w_sub;
  logic                 w_sub_c, w_sec_c, w_min_c, w_hour_c;
  logic                 w_counting, w_tick_en, w_expire, w_load, w_latch_mode, w_clear, w_store;

  assign w_counting = (r_state == ST_RUN) || ((r_state == ST_LAP_STORE) && r_ret_run);
  assign w_tick_en  = iTICK && w_counting;
  // A borrow rippling out of the hour field means every field was zero.
  assign w_expire   = w_hour_c && r_mode_down;
  assign w_clear    = (r_state == ST_CLEAR);
  assign w_store    = (r_state == ST_LAP_STORE) && ((LAP_WRAP != 0) || (r_lap_cnt != LAP_FULL_CNT));
  assign w_time     = {w_hour, w_min, w_sec, w_sub};

  bcd_free_field_cnt #(.MAX(MAX_SUB_SEC)) u_sub (
    .iCLK(iCLK), .iRESETn(iRESETn), .i_clr(w_clear), .i_load(w_load),
    .i_load_val(field_of(iLOAD_TIME, SUB_LSB)), .i_en(w_tick_en), .i_hold(w_expire),
    .i_down(r_mode_down), .o_val(w_sub), .o_carry(w_sub_c));
  bcd_free_field_cnt #(.MAX(MAX_SEC)) u_sec (
    .iCLK(iCLK), .iRESETn(iRESETn), .i_clr(w_clear), .i_load(w_load),
    .i_load_val(field_of(iLOAD_TIME, SEC_LSB)), .i_en(w_sub_c), .i_hold(w_expire),
    .i_down(r_mode_down), .o_val(w_sec), .o_carry(w_sec_c));
  bcd_free_field_cnt #(.MAX(MAX_MIN)) u_min (
    .iCLK(iCLK), .iRESETn(iRESETn), .i_clr(w_clear), .i_load(w_load),
    .i_load_val(field_of(iLOAD_TIME, MIN_LSB)), .i_en(w_sec_c), .i_hold(w_expire),
    .i_down(r_mode_down), .o_val(w_min), .o_carry(w_min_c));
  bcd_free_field_cnt #(.MAX(MAX_HOUR)) u_hour (
    .iCLK(iCLK), .iRESETn(iRESETn), .i_clr(w_clear), .i_load(w_load),
    .i_load_val(field_of(iLOAD_TIME, HOUR_LSB)), .i_en(w_min_c), .i_hold(w_expire),
    .i_down(r_mode_down), .o_val(w_hour), .o_carry(w_hour_c));

  // State register
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state, preset load and mode latch strobes; expiry overrides everything
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_latch_mode = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iSTART) begin w_next = ST_RUN; w_latch_mode = 1'b1; end
        else if (iLOAD) w_load = 1'b1;
      end
      ST_RUN: begin
        if (iSTOP)       w_next = ST_STOP;
        else if (iSTORE) w_next = ST_LAP_STORE;
      end
      ST_STOP: begin
        if (iCLEAR)      w_next = ST_CLEAR;
        else if (iSTART) begin w_next = ST_RUN; w_latch_mode = 1'b1; end
        else if (iSTORE) w_next = ST_LAP_STORE;
        else if (iLOAD)  w_load = 1'b1;
      end
      ST_LAP_STORE: w_next = r_ret_run ? ST_RUN : ST_STOP;
      ST_CLEAR:     w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (w_expire) w_next = ST_STOP;
  end

  // Return flag, latched mode, expiry pulse and clock-generator controls
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_ret_run    <= 1'b0;
      r_mode_down  <= 1'b0;
      r_expired    <= 1'b0;
      r_clkgen_run <= 1'b0;
      r_clkgen_rst <= 1'b0;
    end else begin
      if (r_state != ST_LAP_STORE) r_ret_run <= (r_state == ST_RUN);
      if (w_latch_mode)            r_mode_down <= iMODE_DOWN;
      r_expired    <= w_expire;
      r_clkgen_run <= w_counting;
      r_clkgen_rst <= w_clear;
    end
  end

  // Lap buffer: capture the pre-tick time, advance the pointer, saturate the count
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_lap_cnt <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_lap_cnt <= '0;
    end else if (w_store) begin
      r_lap_mem[r_wr_ptr] <= w_time;
      r_wr_ptr <= (r_wr_ptr == LAP_LAST) ? '0 : r_wr_ptr + LAP_ONE;
      if (r_lap_cnt != LAP_FULL_CNT) r_lap_cnt <= r_lap_cnt + LAP_ONE;
    end
  end

  // Registered lap read port; out-of-range indices read as zero
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn)                      r_lap_data <= '0;
    else if (iLAP_IDX < LAP_FULL_CNT)  r_lap_data <= r_lap_mem[iLAP_IDX];
    else                               r_lap_data <= '0;
  end

  assign oLAP_DATA   = r_lap_data;
  assign oLAP_CNT    = r_lap_cnt;
  assign oLAP_FULL   = (r_lap_cnt == LAP_FULL_CNT);
  assign oCURR_TIME  = w_time;
  assign oEXPIRED    = r_expired;
  assign oCLKGEN_RUN = r_clkgen_run;
  assign oCLKGEN_RST = r_clkgen_rst;
  assign oSTATE      = r_state;

endmodule

// File: tb/tb_stopwatch_core_v2.sv
// tb/tb_stopwatch_core_v2.sv - scoreboard bench for stopwatch_core_v2 with wrap and refuse lap policies
module tb_stopwatch_core_v2;

  localparam int D     = 10;
  localparam int TOTAL = 100 * 60 * 60 * 100;

  logic        iCLK = 1'b0, iRESETn = 1'b0;
  logic        iTICK = 0, iSTART = 0, iSTOP = 0, iCLEAR = 0, iSTORE = 0, iLOAD = 0, iMODE_DOWN = 0;
  logic [31:0] iLOAD_TIME = '0;
  logic [3:0]  iLAP_IDX = '0;

  logic [31:0] o_lap[2], o_time[2];
  logic [3:0]  o_cnt[2];
  logic [2:0]  o_st[2];
  logic        o_full[2], o_exp[2], o_run[2], o_rst[2];

  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  stopwatch_core_v2 #(.LAP_WRAP(1)) dut_w (
    .iCLK(iCLK), .iRESETn(iRESETn), .iTICK(iTICK), .iSTART(iSTART), .iSTOP(iSTOP),
    .iCLEAR(iCLEAR), .iSTORE(iSTORE), .iLOAD(iLOAD), .iLOAD_TIME(iLOAD_TIME),
    .iMODE_DOWN(iMODE_DOWN), .iLAP_IDX(iLAP_IDX), .oLAP_DATA(o_lap[0]), .oLAP_CNT(o_cnt[0]),
    .oLAP_FULL(o_full[0]), .oCURR_TIME(o_time[0]), .oEXPIRED(o_exp[0]),
    .oCLKGEN_RUN(o_run[0]), .oCLKGEN_RST(o_rst[0]), .oSTATE(o_st[0]));

  stopwatch_core_v2 #(.LAP_WRAP(0)) dut_r (
    .iCLK(iCLK), .iRESETn(iRESETn), .iTICK(iTICK), .iSTART(iSTART), .iSTOP(iSTOP),
    .iCLEAR(iCLEAR), .iSTORE(iSTORE), .iLOAD(iLOAD), .iLOAD_TIME(iLOAD_TIME),
    .iMODE_DOWN(iMODE_DOWN), .iLAP_IDX(iLAP_IDX), .oLAP_DATA(o_lap[1]), .oLAP_CNT(o_cnt[1]),
    .oLAP_FULL(o_full[1]), .oCURR_TIME(o_time[1]), .oEXPIRED(o_exp[1]),
    .oCLKGEN_RUN(o_run[1]), .oCLKGEN_RST(o_rst[1]), .oSTATE(o_st[1]));

  typedef struct {
    int          due;
    logic [31:0] tm;
    logic [2:0]  st;
    logic        run, rst, ex, full;
    logic [3:0]  cnt;
    logic [31:0] lap_w, lap_r;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model: time as total centiseconds, laps as the list of every capture
  int          m_st = 0, m_t = 0;
  bit          m_ret = 0, m_down = 0;
  logic [31:0] caps[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] to_word(input int t);
    int c, s, m, h;
    c = t % 100; s = (t / 100) % 60; m = (t / 6000) % 60; h = t / 360000;
    return {8'(h), 8'(m), 8'(s), 8'(c)};
  endfunction

  function automatic int from_word(input logic [31:0] w);
    int c, s, m, h;
    h = int'(w[31:24]); m = int'(w[23:16]); s = int'(w[15:8]); c = int'(w[7:0]);
    if (h >= 100) h = 0;
    if (m >= 60)  m = 0;
    if (s >= 60)  s = 0;
    if (c >= 100) c = 0;
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  // Policy 0 (wrap): newest capture whose sequence number lands on slot i.
  // Policy 1 (refuse): only the first D captures are ever kept.
  function automatic logic [31:0] entry(input int pol, input int i);
    int n;
    n = caps.size();
    if (i >= D) return '0;
    if (pol == 0) begin
      for (int k = n - 1; k >= 0; k--) if (k % D == i) return caps[k];
      return '0;
    end
    return (i < n) ? caps[i] : '0;
  endfunction

  task automatic model_step(output exp_t e);
    bit counting;
    int nst, n;
    counting = (m_st == 1) || (m_st == 3 && m_ret);
    nst      = m_st;
    e.due    = cyc + 1;
    e.lap_w  = entry(0, int'(iLAP_IDX));
    e.lap_r  = entry(1, int'(iLAP_IDX));
    e.run    = counting;
    e.rst    = (m_st == 4);
    e.ex     = 1'b0;
    if (m_st == 3) caps.push_back(to_word(m_t));
    case (m_st)
      0: if (iSTART) begin nst = 1; m_down = iMODE_DOWN; end
         else if (iLOAD) m_t = from_word(iLOAD_TIME);
      1: if (iSTOP) nst = 2; else if (iSTORE) nst = 3;
      2: if (iCLEAR) nst = 4;
         else if (iSTART) begin nst = 1; m_down = iMODE_DOWN; end
         else if (iSTORE) nst = 3;
         else if (iLOAD) m_t = from_word(iLOAD_TIME);
      3: nst = m_ret ? 1 : 2;
      default: begin nst = 0; m_t = 0; caps.delete(); end
    endcase
    if (nst == 3) m_ret = (m_st == 1);
    if (counting && iTICK) begin
      if (!m_down)        m_t = (m_t + 1) % TOTAL;
      else if (m_t == 0) begin e.ex = 1'b1; nst = 2; end
      else                m_t = m_t - 1;
    end
    m_st   = nst;
    n      = caps.size();
    e.tm   = to_word(m_t);
    e.st   = 3'(m_st);
    e.cnt  = 4'((n > D) ? D : n);
    e.full = (n >= D);
  endtask

  // Monitor: pops the expectation due for this cycle and compares both DUTs
  always @(negedge iCLK) begin
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      check("sb_stale_due", 32'(sb_q[0].due), 32'(cyc));
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        check(d == 0 ? "w_time" : "r_time", o_time[d], mon_e.tm);
        check(d == 0 ? "w_state" : "r_state", 32'(o_st[d]), 32'(mon_e.st));
        check(d == 0 ? "w_clkgen_run" : "r_clkgen_run", 32'(o_run[d]), 32'(mon_e.run));
        check(d == 0 ? "w_clkgen_rst" : "r_clkgen_rst", 32'(o_rst[d]), 32'(mon_e.rst));
        check(d == 0 ? "w_expired" : "r_expired", 32'(o_exp[d]), 32'(mon_e.ex));
        check(d == 0 ? "w_lap_cnt" : "r_lap_cnt", 32'(o_cnt[d]), 32'(mon_e.cnt));
        check(d == 0 ? "w_lap_full" : "r_lap_full", 32'(o_full[d]), 32'(mon_e.full));
      end
      check("w_lap_data", o_lap[0], mon_e.lap_w);
      check("r_lap_data", o_lap[1], mon_e.lap_r);
    end
  end

  task automatic step();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
    @(posedge iCLK); #1;
    {iSTART, iSTOP, iCLEAR, iSTORE, iLOAD, iTICK} = '0;
  endtask

  task automatic drive(input logic st, input logic sp, input logic cl,
                       input logic sr, input logic ld, input logic tk);
    iSTART = st; iSTOP = sp; iCLEAR = cl; iSTORE = sr; iLOAD = ld; iTICK = tk;
    step();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once
  task automatic do_reset();
    @(negedge iCLK); #1;
    {iSTART, iSTOP, iCLEAR, iSTORE, iLOAD, iTICK} = '0;
    iRESETn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_time", o_time[d], 32'h0);
      check("rst_state", 32'(o_st[d]), 32'h0);
      check("rst_cnt_full", {o_cnt[d], o_full[d], o_exp[d], o_run[d], o_rst[d]}, 32'h0);
      check("rst_lap_data", o_lap[d], 32'h0);
    end
    m_st = 0; m_t = 0; m_ret = 0; m_down = 0; caps.delete();
    @(posedge iCLK);
    @(negedge iCLK);
    iRESETn = 1'b1;
    @(posedge iCLK); #1;
  endtask

  initial begin
    do_reset();

    // Up count: 6000 ticks is exactly one minute
    iMODE_DOWN = 0;
    drive(1, 0, 0, 0, 0, 0);
    repeat (6000) drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("up_one_minute", o_time[0], 32'h00010000);
    check("up_run_off_after_stop", 32'(o_run[0]), 32'h0);
    check("up_state_stop", 32'(o_st[0]), 32'h2);

    // Countdown from 5 and restart at zero
    do_reset();
    iLOAD_TIME = 32'h00000005;
    drive(0, 0, 0, 0, 1, 0);
    iMODE_DOWN = 1;
    drive(1, 0, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 1);
    check("down_zero_after_5", o_time[0], 32'h0);
    check("down_no_early_expire", 32'(o_exp[0]), 32'h0);
    drive(0, 0, 0, 0, 0, 1);
    check("down_expire_pulse", 32'(o_exp[0]), 32'h1);
    check("down_forced_stop", 32'(o_st[0]), 32'h2);
    drive(0, 0, 0, 0, 0, 0);
    check("down_expire_one_cycle", 32'(o_exp[0]), 32'h0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("down_restart_at_zero", 32'(o_exp[0]), 32'h1);

    // Preset clamping and full up rollover
    do_reset();
    iMODE_DOWN = 0;
    iLOAD_TIME = 32'h64403B10;
    drive(0, 0, 0, 0, 1, 0);
    check("load_clamp", o_time[0], 32'h00003B10);
    iLOAD_TIME = 32'h633B3B63;
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("up_full_rollover", o_time[0], 32'h0);

    // Lap store coinciding with a tick captures the pre-tick time
    do_reset();
    iLOAD_TIME = 32'h00000063;
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("store_tick_current", o_time[0], 32'h00000100);
    iLAP_IDX = 0;
    drive(0, 0, 0, 0, 0, 0);
    check("store_tick_lap", o_lap[0], 32'h00000063);

    // Twelve stores: wrap overwrites the oldest, refuse keeps the first ten
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
    end
    for (int d = 0; d < 2; d++) begin
      check("laps_cnt_saturated", 32'(o_cnt[d]), 32'd10);
      check("laps_full", 32'(o_full[d]), 32'h1);
    end
    iLAP_IDX = 0; drive(0, 0, 0, 0, 0, 0);
    check("wrap_entry0_is_11th", o_lap[0], caps[10]);
    check("refuse_entry0_is_1st", o_lap[1], caps[0]);
    iLAP_IDX = 1; drive(0, 0, 0, 0, 0, 0);
    check("wrap_entry1_is_12th", o_lap[0], caps[11]);
    iLAP_IDX = 12; drive(0, 0, 0, 0, 0, 0);
    check("lap_idx_out_of_range", o_lap[0], 32'h0);

    // Clear from STOP wipes time and laps and pulses the clock-gen reset once
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("clear_state", 32'(o_st[0]), 32'h4);
    drive(0, 0, 0, 0, 0, 0);
    check("clear_rst_pulse", 32'(o_rst[0]), 32'h1);
    check("clear_idle", 32'(o_st[0]), 32'h0);
    check("clear_time", o_time[0], 32'h0);
    check("clear_cnt", 32'(o_cnt[1]), 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    check("clear_rst_single", 32'(o_rst[0]), 32'h0);
    for (int i = 0; i < 16; i++) begin
      iLAP_IDX = 4'(i);
      drive(0, 0, 0, 0, 0, 0);
      check("clear_lap_zero", o_lap[0] | o_lap[1], 32'h0);
    end

    // Randomised traffic including small countdowns and mid-run resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      iMODE_DOWN = 1'($urandom_range(0, 1));
      iLAP_IDX   = 4'($urandom_range(0, 15));
      iLOAD_TIME[7:0]   = 8'($urandom_range(0, 120));
      iLOAD_TIME[15:8]  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 70));
      iLOAD_TIME[23:16] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 70));
      iLOAD_TIME[31:24] = ($urandom_range(0, 3) != 0) ? 8'd0 : 8'($urandom_range(0, 120));
      drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    @(negedge iCLK); #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
